window7_scan_ctrl: RTL

//  Sequencing controller for the 7x7 neighbourhood datapath of the noise filter.

---
 rtl/window7_scan_ctrl_if.sv | 33 +++
 rtl/window7_scan_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/window7_scan_ctrl_if.sv
// Interface bundle for window7_scan_ctrl.
// Groups the pixel-source handshake (sof, pix_valid) with the controls that
// the controller drives toward the 7x7 window datapath and line buffers.
//   slave  : the controller side (takes sof/pix_valid, drives the rest)
//   master : the source/datapath side (drives sof/pix_valid, observes the rest)
interface window7_scan_ctrl_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  logic          sof;
  logic          pix_valid;
  logic          shift_en;
  logic [XW-1:0] lb_addr;
  logic          lb_wr_en;
  logic [2:0]    lb_head;
  logic          win_valid;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic          frame_done;
  logic          sync_err;

  modport slave (
    input  sof, pix_valid,
    output shift_en, lb_addr, lb_wr_en, lb_head,
           win_valid, win_x, win_y, frame_done, sync_err
  );

  modport master (
    output sof, pix_valid,
    input  shift_en, lb_addr, lb_wr_en, lb_head,
           win_valid, win_x, win_y, frame_done, sync_err
  );
endinterface

// File: rtl/window7_scan_ctrl.sv
// Sequencing controller for the WINxWIN neighbourhood datapath.
// Tracks the raster position of the accepted pixel stream, enables the tap
// shift registers, addresses and rotates the WIN-1 line buffers, and flags each
// complete window together with its centre coordinate. Carries no pixel data.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset
//   bus  - window7_scan_ctrl_if.slave:
//          sof/pix_valid in; shift_en, lb_addr, lb_wr_en combinational;
//          lb_head, win_valid, win_x, win_y, frame_done registered; sync_err sticky
module window7_scan_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int WIN   = 7,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input  logic               clk,
  input  logic               rst,
  window7_scan_ctrl_if.slave bus
);

  localparam int            HALF      = (WIN - 1) / 2;
  localparam logic [XW-1:0] COL_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] ROW_LAST  = YW'(IMG_H - 1);
  localparam logic [XW-1:0] COL_MIN   = XW'(WIN - 1);
  localparam logic [YW-1:0] ROW_MIN   = YW'(WIN - 1);
  localparam logic [2:0]    HEAD_LAST = 3'(WIN - 2);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t        state;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [2:0]    lb_head;
  logic          win_valid;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic          frame_done;
  logic          sync_err;

  logic          accept;
  logic          restart;
  logic          line_end;
  logic          frame_end;
  logic [XW-1:0] cur_col;
  logic [YW-1:0] cur_row;
  logic [2:0]    cur_head;

  // Position of the pixel on the bus this cycle. A sof pixel is (0,0) with
  // buffer 0 as oldest, regardless of where the counters currently stand.
  always_comb begin
    // NOTE: accept is gated by rst so the combinational strobes are already
    // low while reset is held, matching the registered outputs.
    accept    = rst && bus.pix_valid && (state == ACTIVE || bus.sof);
    restart   = accept && bus.sof;
    cur_col   = restart ? '0 : col;
    cur_row   = restart ? '0 : row;
    cur_head  = restart ? '0 : lb_head;
    line_end  = (cur_col == COL_LAST);
    frame_end = line_end && (cur_row == ROW_LAST);
  end

  assign bus.shift_en   = accept;
  assign bus.lb_wr_en   = accept;
  assign bus.lb_addr    = cur_col;
  assign bus.lb_head    = lb_head;
  assign bus.win_valid  = win_valid;
  assign bus.win_x      = win_x;
  assign bus.win_y      = win_y;
  assign bus.frame_done = frame_done;
  assign bus.sync_err   = sync_err;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of cur_col/cur_row/state consistently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      lb_head    <= '0;
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;

      // A pixel outside a frame that is not a frame start means the source
      // and controller disagree about framing; remember it until reset.
      if (bus.pix_valid && !bus.sof && state != ACTIVE)
        sync_err <= 1'b1;

      if (accept) begin
        if (line_end) begin
          col     <= '0;
          row     <= frame_end ? '0 : cur_row + 1'b1;
          // The buffer that held the oldest line is overwritten by the line
          // just finished, so the next one along becomes the oldest.
          lb_head <= (cur_head == HEAD_LAST) ? '0 : cur_head + 3'd1;
        end else begin
          col     <= cur_col + 1'b1;
          row     <= cur_row;
          lb_head <= cur_head;
        end

        // The window completes on its bottom-right pixel; the centre sits
        // HALF back in both directions. Left edge limit prevents straddling.
        if (cur_col >= COL_MIN && cur_row >= ROW_MIN) begin
          win_valid <= 1'b1;
          win_x     <= cur_col - XW'(HALF);
          win_y     <= cur_row - YW'(HALF);
        end
      end

      if (accept && frame_end) begin
        state      <= DONE;
        frame_done <= 1'b1;
      end else if (accept) begin
        state <= ACTIVE;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

endmodule
